// File: rtl/sparc_decode_stage_if.sv
// Signal bundle for the SPARC decode stage: fetch input, execute-side output slot and writeback port.
// The master modport is the surrounding pipeline; the slave modport is the decode stage itself.
interface sparc_decode_stage_if;
    logic [31:0] DEC_instr_in;
    logic [31:0] DEC_PC_in;
    logic        DEC_valid_in;
    logic        DEC_ready_out;
    logic        DEC_ready_in;
    logic        DEC_valid_out;
    logic        DEC_flush_in;
    logic        DEC_wb_en_in;
    logic [4:0]  DEC_wb_rd_in;
    logic [31:0] DEC_wb_data_in;
    logic [31:0] DEC_valA_out;
    logic [31:0] DEC_valB_out;
    logic [1:0]  DEC_op_out;
    logic [2:0]  DEC_op2_out;
    logic [5:0]  DEC_op3_out;
    logic [4:0]  DEC_rd_out;
    logic        DEC_a_out;
    logic [3:0]  DEC_cond_out;
    logic        DEC_i_out;
    logic [12:0] DEC_simm13_out;
    logic [21:0] DEC_imm22_out;
    logic [29:0] DEC_disp30_out;
    logic [31:0] DEC_PC_out;

    modport master (
        output DEC_instr_in, DEC_PC_in, DEC_valid_in, DEC_ready_in, DEC_flush_in,
        output DEC_wb_en_in, DEC_wb_rd_in, DEC_wb_data_in,
        input  DEC_ready_out, DEC_valid_out, DEC_valA_out, DEC_valB_out,
        input  DEC_op_out, DEC_op2_out, DEC_op3_out, DEC_rd_out, DEC_a_out, DEC_cond_out,
        input  DEC_i_out, DEC_simm13_out, DEC_imm22_out, DEC_disp30_out, DEC_PC_out
    );

    modport slave (
        input  DEC_instr_in, DEC_PC_in, DEC_valid_in, DEC_ready_in, DEC_flush_in,
        input  DEC_wb_en_in, DEC_wb_rd_in, DEC_wb_data_in,
        output DEC_ready_out, DEC_valid_out, DEC_valA_out, DEC_valB_out,
        output DEC_op_out, DEC_op2_out, DEC_op3_out, DEC_rd_out, DEC_a_out, DEC_cond_out,
        output DEC_i_out, DEC_simm13_out, DEC_imm22_out, DEC_disp30_out, DEC_PC_out
    );
endinterface

// File: rtl/sparc_decode_stage.sv
// SPARC decode/operand-fetch stage: flat 32x32 register file with writeback bypass,
// format-field split and a single registered output slot under valid/ready with flush.
module sparc_decode_stage #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic            DEC_clk_in,
    input logic            DEC_rst_n_in,
    sparc_decode_stage_if.slave dec
);

    logic [31:0] r_regs [NREGS];
    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_valA;
    logic [31:0] r_valB;
    logic        r_valid;

    logic        w_ready;
    logic        w_accept;
    logic        w_consume;
    logic        w_wbWrite;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [31:0] w_valA;
    logic [31:0] w_valB;

    assign w_ready   = !r_valid || dec.DEC_ready_in;
    assign w_accept  = dec.DEC_valid_in && w_ready && !dec.DEC_flush_in;
    assign w_consume = r_valid && dec.DEC_ready_in;
    assign w_wbWrite = dec.DEC_wb_en_in && (dec.DEC_wb_rd_in != 5'd0);
    assign w_rs1     = dec.DEC_instr_in[18:14];
    assign w_rs2     = dec.DEC_instr_in[4:0];

    // Operand read with same-cycle writeback bypass; r0 is hard-wired to zero.
    always_comb begin
        w_valA = r_regs[w_rs1];
        w_valB = r_regs[w_rs2];
        if (w_rs1 == 5'd0) begin
            w_valA = '0;
        end else if (w_wbWrite && (dec.DEC_wb_rd_in == w_rs1)) begin
            w_valA = dec.DEC_wb_data_in;
        end
        if (w_rs2 == 5'd0) begin
            w_valB = '0;
        end else if (w_wbWrite && (dec.DEC_wb_rd_in == w_rs2)) begin
            w_valB = dec.DEC_wb_data_in;
        end
    end

    always_ff @(posedge DEC_clk_in or negedge DEC_rst_n_in) begin
        if (!DEC_rst_n_in) begin
            for (int k = 0; k < NREGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_wbWrite) begin
            r_regs[dec.DEC_wb_rd_in] <= dec.DEC_wb_data_in;
        end
    end

    // Output slot: flush wins, otherwise load on accept, otherwise drain when consumed.
    always_ff @(posedge DEC_clk_in or negedge DEC_rst_n_in) begin
        if (!DEC_rst_n_in) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= RESET_PC;
            r_valA  <= '0;
            r_valB  <= '0;
        end else if (dec.DEC_flush_in) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_instr <= dec.DEC_instr_in;
            r_pc    <= dec.DEC_PC_in;
            r_valA  <= w_valA;
            r_valB  <= w_valB;
        end else if (w_consume) begin
            r_valid <= 1'b0;
        end
    end

    assign dec.DEC_ready_out  = w_ready;
    assign dec.DEC_valid_out  = r_valid;
    assign dec.DEC_valA_out   = r_valA;
    assign dec.DEC_valB_out   = r_valB;
    assign dec.DEC_PC_out     = r_pc;
    assign dec.DEC_op_out     = r_instr[31:30];
    assign dec.DEC_op2_out    = r_instr[24:22];
    assign dec.DEC_op3_out    = r_instr[24:19];
    assign dec.DEC_rd_out     = r_instr[29:25];
    assign dec.DEC_a_out      = r_instr[29];
    assign dec.DEC_cond_out   = r_instr[28:25];
    assign dec.DEC_i_out      = r_instr[13];
    assign dec.DEC_simm13_out = r_instr[12:0];
    assign dec.DEC_imm22_out  = r_instr[21:0];
    assign dec.DEC_disp30_out = r_instr[29:0];

endmodule
